// File: rtl/hazard_scoreboard.sv
// RAW hazard unit: per-register countdown scoreboard with stall perf counter.
// Optional HAZARD_FWD_EN: forwarding latencies (ALU 0, load 1).
module hazard_scoreboard #(
  parameter int REG_AW   = 3,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 2,
  parameter int LAT_ALU  = 2,
  parameter int LAT_LOAD = 2,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_id,
  input  logic [REG_AW-1:0] rs_id,
  input  logic              rs_active_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              rt_active_id,
  input  logic [REG_AW-1:0] wr_reg_id,
  input  logic              reg_write_id,
  input  logic              is_load_id,
  input  logic              flush_id,
  input  logic              freeze,
  output logic              stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [PERF_W-1:0] stall_count
);

`ifdef HAZARD_FWD_EN
  localparam int EFF_ALU  = 0;
  localparam int EFF_LOAD = 1;
`else
  localparam int EFF_ALU  = LAT_ALU;
  localparam int EFF_LOAD = LAT_LOAD;
`endif

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] nxt [NUM_REGS];
  logic [CNT_W-1:0] lat;
  logic             haz;
  logic             issue;
  logic             rs_busy;
  logic             rt_busy;

  assign rs_busy = rs_active_id && (cnt[rs_id] != '0);
  assign rt_busy = rt_active_id && (cnt[rt_id] != '0);
  assign haz     = valid_id && !flush_id && (rs_busy || rt_busy);
  assign stall   = haz && !rst;
  assign issue   = valid_id && !flush_id && !stall && !freeze && !rst;
  assign lat     = is_load_id ? CNT_W'(EFF_LOAD) : CNT_W'(EFF_ALU);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // Arming keeps the larger of the remaining and new latency (WAW safety).
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      nxt[r] = (cnt[r] == '0) ? '0 : cnt[r] - 1'b1;
      if (issue && reg_write_id && (wr_reg_id == REG_AW'(r))) begin
        if (lat > nxt[r]) nxt[r] = lat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      stall_count <= '0;
    end else if (!freeze) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= nxt[r];
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
